imem_loader: RTL and testbench

//  Writer side of the instruction memory: receives a program as a byte stream and writes it

---
 rtl/imem_loader_pkg.sv | 29 ++
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader_byte_packer.sv | 61 ++++++
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Brief    : Shared loader FSM encoding and instruction-memory geometry.
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;
    localparam int IMEM_ADDR_W    = 8;
    localparam int CNT_W          = 8 * HDR_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    function automatic logic is_loading(input state_t s);
        return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Brief    : Host byte link plus imem synchronous write port.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_W = imem_loader_pkg::IMEM_ADDR_W,
    parameter int DATA_W = 32
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_byte_packer
// Brief    : Assembles little-endian bytes into words; one-cycle word_valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              clr,
    input  wire logic              byte_en,
    input  wire logic [7:0]        byte_in,
    output logic                   last_byte,
    output logic                   word_valid,
    output logic [DATA_W-1:0]      word_data
);

    localparam int              c_IDX_W   = $clog2(BYTES_PER_WORD);
    localparam int              c_SHIFT_W = DATA_W - 8;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(BYTES_PER_WORD - 1);

    logic [c_IDX_W-1:0]   r_cnt;
    logic [c_SHIFT_W-1:0] r_shift;
    logic                 r_word_valid;
    logic [DATA_W-1:0]    r_word_data;
    logic [DATA_W-1:0]    w_word;

    // Bytes enter at the top so the first byte ends up in bits [7:0].
    assign w_word    = {byte_in, r_shift};
    assign last_byte = (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_word_valid <= 1'b0;
            r_word_data  <= '0;
        end else begin
            r_word_valid <= byte_en && last_byte;
            if (clr) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (byte_en) begin
                r_cnt   <= r_cnt + 1'b1;
                r_shift <= w_word[DATA_W-1:8];
                if (last_byte) begin
                    r_word_data <= w_word;
                end
            end
        end
    end

    assign word_valid = r_word_valid;
    assign word_data  = r_word_data;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Streams a counted, checksummed program into imem while holding the CPU.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = 32
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input  wire logic           start,
    imem_loader_if.slave        bus,
    output logic                cpu_hold,
    output logic                done,
    output logic                error,
    output logic [ADDR_W:0]     words_loaded
);

    localparam logic [31:0] c_MAX_WORDS = 32'(2 ** ADDR_W);

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_count;
    logic [7:0]          r_csum;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_words;

    logic                w_accept;
    logic                w_enter_hdr0;
    logic                w_data_byte;
    logic                w_last_byte;
    logic                w_word_done;
    logic                w_last_word;
    logic [CNT_W-1:0]    w_hdr_n;
    logic [ADDR_W:0]     w_words_next;
    logic                w_word_valid;
    logic [DATA_W-1:0]   w_word_data;

    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_enter_hdr0 = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_data_byte  = w_accept && (r_state == ST_DATA);
    assign w_word_done  = w_data_byte && w_last_byte;
    assign w_hdr_n      = {bus.in_data, r_count[7:0]};
    assign w_words_next = r_words + 1'b1;
    assign w_last_word  = (CNT_W'(w_words_next) == r_count);

    imem_loader_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (w_enter_hdr0),
        .byte_en    (w_data_byte),
        .byte_in    (bus.in_data),
        .last_byte  (w_last_byte),
        .word_valid (w_word_valid),
        .word_data  (w_word_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        bus.in_ready = is_loading(r_state);
        cpu_hold     = is_loading(r_state) || (r_state == ST_ERR);
        done         = (r_state == ST_DONE);
        error        = (r_state == ST_ERR);
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) w_state_next = ST_HDR0;
            end
            ST_HDR0: begin
                if (w_accept) w_state_next = ST_HDR1;
            end
            ST_HDR1: begin
                if (w_accept) begin
                    if (32'(w_hdr_n) > c_MAX_WORDS) w_state_next = ST_ERR;
                    else if (w_hdr_n == '0)        w_state_next = ST_CSUM;
                    else                           w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_word_done && w_last_word) w_state_next = ST_CSUM;
            end
            ST_CSUM: begin
                if (w_accept) w_state_next = (bus.in_data == r_csum) ? ST_DONE : ST_ERR;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Address is captured with the word so it stays put once the index moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_csum  <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_words <= '0;
        end else if (w_enter_hdr0) begin
            r_count <= '0;
            r_csum  <= '0;
            r_idx   <= '0;
            r_words <= '0;
        end else begin
            if (w_accept && (r_state == ST_HDR0)) r_count[7:0]  <= bus.in_data;
            if (w_accept && (r_state == ST_HDR1)) r_count[15:8] <= bus.in_data;
            if (w_data_byte) r_csum <= r_csum ^ bus.in_data;
            if (w_word_done) begin
                r_addr  <= r_idx;
                r_idx   <= r_idx + 1'b1;
                r_words <= w_words_next;
            end
        end
    end

    assign bus.mem_we    = w_word_valid;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = w_word_data;
    assign words_loaded  = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Randomised scoreboard bench for the imem program loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int ADDR_W = IMEM_ADDR_W;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus();

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bus          (bus.slave),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] words_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit noise, output bit ok);
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                bus.in_valid = 1'b0;
                if (noise && ($urandom_range(0, 2) == 0)) start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) ok = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic check_idle_result(input string tag, input bit exp_done, input int exp_words);
        check({tag, "_done"},         64'(done),         64'(exp_done));
        check({tag, "_error"},        64'(error),        64'(!exp_done));
        check({tag, "_cpu_hold"},     64'(cpu_hold),     64'(!exp_done));
        check({tag, "_in_ready"},     64'(bus.in_ready), 64'(0));
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'(exp_words));
    endtask

    // Reference: a program of n words from words_q; checksum is the XOR of its bytes.
    task automatic do_load(input string tag, input int n, input logic [7:0] flip,
                           input bit gaps, input bit noise);
        logic [7:0]  cs;
        logic [15:0] n16;
        logic [31:0] w;
        logic [7:0]  b;
        wr_t         e;
        bit          ok;
        cs  = 8'h00;
        n16 = 16'(n);
        pulse_start();
        send_byte(n16[7:0], gaps, noise, ok);
        check({tag, "_hdr0_accept"}, 64'(ok), 64'(1));
        send_byte(n16[15:8], gaps, noise, ok);
        check({tag, "_hdr1_accept"}, 64'(ok), 64'(1));
        if (n > 2 ** ADDR_W) begin
            repeat (3) tick();
            check({tag, "_oversize_error"},    64'(error),        64'(1));
            check({tag, "_oversize_hold"},     64'(cpu_hold),     64'(1));
            check({tag, "_oversize_in_ready"}, 64'(bus.in_ready), 64'(0));
            check({tag, "_oversize_done"},     64'(done),         64'(0));
            check({tag, "_oversize_words"},    64'(words_loaded), 64'(0));
            return;
        end
        for (int i = 0; i < n; i++) begin
            w      = words_q[i];
            e.addr = ADDR_W'(i);
            e.data = w;
            exp_q.push_back(e);
            for (int k = 0; k < 4; k++) begin
                b  = w[8*k +: 8];
                cs = cs ^ b;
                send_byte(b, gaps, noise, ok);
                if (!ok) begin
                    check({tag, "_payload_accept"}, 64'(ok), 64'(1));
                    exp_q.delete();
                    return;
                end
            end
        end
        send_byte(cs ^ flip, gaps, noise, ok);
        check({tag, "_csum_accept"}, 64'(ok), 64'(1));
        repeat (3) tick();
        check({tag, "_writes_drained"}, 64'(exp_q.size()), 64'(0));
        check_idle_result(tag, (flip == 8'h00), n);
    endtask

    task automatic set_scenario2();
        words_q.delete();
        words_q.push_back(32'h0000_0007);
        words_q.push_back(32'h0000_000F);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  64'(bus.in_ready),  64'(0));
        check({tag, "_mem_we"},    64'(bus.mem_we),    64'(0));
        check({tag, "_mem_addr"},  64'(bus.mem_addr),  64'(0));
        check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(0));
        check({tag, "_cpu_hold"},  64'(cpu_hold),      64'(0));
        check({tag, "_done"},      64'(done),          64'(0));
        check({tag, "_error"},     64'(error),         64'(0));
        check({tag, "_words"},     64'(words_loaded),  64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        int         n;
        logic [7:0] flip;
        bit         gaps;
        wr_t        e;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        fork
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1 && bus.mem_we === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                                 bus.mem_addr, bus.mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_addr", 64'(bus.mem_addr),  64'(e.addr));
                        check("write_data", 64'(bus.mem_wdata), 64'(e.data));
                    end
                end
            end
        join_none

        #2;
        check_all_zero("reset");
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        set_scenario2();
        do_load("s2", 2, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a load, off the clock edge.
        pulse_start();
        send_byte(8'h02, 1'b0, 1'b0, ok);
        send_byte(8'h00, 1'b0, 1'b0, ok);
        send_byte(8'h11, 1'b0, 1'b0, ok);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();

        words_q.delete();
        do_load("s3_empty", 0, 8'h00, 1'b0, 1'b0);

        do_load("s4_oversize", 257, 8'h00, 1'b0, 1'b0);

        set_scenario2();
        do_load("s5_badcsum", 2, 8'h01, 1'b0, 1'b0);
        do_load("s5_recover", 2, 8'h00, 1'b0, 1'b0);

        set_scenario2();
        do_load("s6_gaps", 2, 8'h00, 1'b1, 1'b1);

        // Reset after the first word is written, then reload from scratch.
        pulse_start();
        send_byte(8'h02, 1'b0, 1'b0, ok);
        send_byte(8'h00, 1'b0, 1'b0, ok);
        e.addr = '0;
        e.data = 32'h0000_0007;
        exp_q.push_back(e);
        send_byte(8'h07, 1'b0, 1'b0, ok);
        send_byte(8'h00, 1'b0, 1'b0, ok);
        send_byte(8'h00, 1'b0, 1'b0, ok);
        send_byte(8'h00, 1'b0, 1'b0, ok);
        for (int t = 0; t < 5 && exp_q.size() != 0; t++) tick();
        check("s6_first_word_written", 64'(exp_q.size()), 64'(0));
        check("s6_mid_words", 64'(words_loaded), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_rst_hold",  64'(cpu_hold),     64'(0));
        check("s6_rst_words", 64'(words_loaded), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        check("s6_idle_ready", 64'(bus.in_ready), 64'(0));
        do_load("s6_reload", 2, 8'h00, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(0, 6);
            words_q.delete();
            for (int i = 0; i < n; i++) words_q.push_back($urandom);
            flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            gaps = 1'($urandom_range(0, 1));
            do_load("rand", n, flip, gaps, gaps);
        end

        words_q.delete();
        for (int i = 0; i < 256; i++) words_q.push_back($urandom);
        do_load("full", 256, 8'h00, 1'b0, 1'b0);

        do_load("rand_oversize", int'($urandom_range(258, 65535)), 8'h00, 1'b0, 1'b0);

        words_q.delete();
        for (int i = 0; i < 3; i++) words_q.push_back($urandom);
        do_load("after_err", 3, 8'h00, 1'b1, 1'b0);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
